// File: rtl/dsp48a1_chk_pkg.sv
// rtl/dsp48a1_chk_pkg.sv - shared constants and types for the DSP48A1 result checker
//
// Contents:
//   OPM_*        bit positions of the OPMODE fields decoded by the golden model
//   XMUX_*/ZMUX_* select codes of the X and Z post-adder multiplexers
//   exp_rec_t    one delay-line entry {valid, expected P, expected CARRYOUT}
//   chk_state_t  checker FSM states
package dsp48a1_chk_pkg;

    localparam int OPM_X_LSB      = 0;
    localparam int OPM_X_MSB      = 1;
    localparam int OPM_Z_LSB      = 2;
    localparam int OPM_Z_MSB      = 3;
    localparam int OPM_PREADD_EN  = 4;
    localparam int OPM_CIN        = 5;
    localparam int OPM_PREADD_SUB = 6;
    localparam int OPM_POST_SUB   = 7;

    localparam logic [1:0] XMUX_ZERO = 2'd0;
    localparam logic [1:0] XMUX_M    = 2'd1;
    localparam logic [1:0] XMUX_P    = 2'd2;
    localparam logic [1:0] XMUX_DAB  = 2'd3;

    localparam logic [1:0] ZMUX_ZERO = 2'd0;
    localparam logic [1:0] ZMUX_PCIN = 2'd1;
    localparam logic [1:0] ZMUX_P    = 2'd2;
    localparam logic [1:0] ZMUX_C    = 2'd3;

    typedef struct packed {
        logic        valid;
        logic [47:0] p;
        logic        co;
    } exp_rec_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FAIL = 2'd2
    } chk_state_t;

endpackage

// File: rtl/dsp48a1_golden_model.sv
// rtl/dsp48a1_golden_model.sv - combinational transaction-level model of the DSP48A1 datapath
//
// Ports:
//   opmode      DSP opmode of the transaction
//   a, b, d     18-bit operands
//   c, pcin     48-bit operands
//   pm          model's previous expected P (feedback path for the P mux codes)
//   p, co       expected P and CARRYOUT
module dsp48a1_golden_model
    import dsp48a1_chk_pkg::*;
(
    input  logic [7:0]  opmode,
    input  logic [17:0] a,
    input  logic [17:0] b,
    input  logic [17:0] d,
    input  logic [47:0] c,
    input  logic [47:0] pcin,
    input  logic [47:0] pm,
    output logic [47:0] p,
    output logic        co
);

    logic [17:0] b_pre;
    logic [35:0] m;
    logic [47:0] x;
    logic [47:0] z;
    logic [48:0] s;
    logic        cin;

    always_comb begin
        // Pre-adder result wraps to 18 bits like the hard block.
        b_pre = b;
        if (opmode[OPM_PREADD_EN]) begin
            b_pre = opmode[OPM_PREADD_SUB] ? (d - b) : (d + b);
        end

        m = {18'd0, a} * {18'd0, b_pre};

        x = 48'd0;
        case (opmode[OPM_X_MSB:OPM_X_LSB])
            XMUX_ZERO: x = 48'd0;
            XMUX_M:    x = {12'd0, m};
            XMUX_P:    x = pm;
            XMUX_DAB:  x = {d[11:0], a, b};
            default:   x = 48'd0;
        endcase

        z = 48'd0;
        case (opmode[OPM_Z_MSB:OPM_Z_LSB])
            ZMUX_ZERO: z = 48'd0;
            ZMUX_PCIN: z = pcin;
            ZMUX_P:    z = pm;
            ZMUX_C:    z = c;
            default:   z = 48'd0;
        endcase

        cin = opmode[OPM_CIN];

        // 49-bit arithmetic: bit 48 is the carry on add and the borrow on subtract.
        if (opmode[OPM_POST_SUB]) begin
            s = {1'b0, z} - ({1'b0, x} + {48'd0, cin});
        end else begin
            s = {1'b0, z} + {1'b0, x} + {48'd0, cin};
        end

        p  = s[47:0];
        co = s[48];
    end

endmodule

// File: rtl/dsp48a1_result_checker.sv
// rtl/dsp48a1_result_checker.sv - in-fabric response checker for the DSP48A1 block
//
// Optional macro DSP_CHK_CARRYOUT_EN: when defined CARRYOUT is compared along
// with P; otherwise only P is compared and CARRYOUT is ignored.
//
// Ports:
//   CLK, RST            clock, asynchronous active-high reset
//   START, STOP         arm / end checking (pulses, STOP has priority)
//   IN_VALID            OPMODE/A/B/D/C/PCIN form one transaction this cycle
//   P, CARRYOUT         DSP outputs under test, LATENCY cycles after the transaction
//   ERR                 one-cycle pulse on a mismatch
//   MATCH_CNT, ERR_CNT  saturating pass / fail counters
//   FIRST_EXP/FIRST_GOT expected and observed P of the first mismatch
//   BUSY, FAIL          FSM is in RUN / FAIL
module dsp48a1_result_checker
    import dsp48a1_chk_pkg::*;
#(
    parameter int LATENCY     = 3,
    parameter int STOP_ON_ERR = 0,
    parameter int CNT_W       = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             STOP,
    input  logic             IN_VALID,
    input  logic [7:0]       OPMODE,
    input  logic [17:0]      A,
    input  logic [17:0]      B,
    input  logic [17:0]      D,
    input  logic [47:0]      C,
    input  logic [47:0]      PCIN,
    input  logic [47:0]      P,
    input  logic             CARRYOUT,
    output logic             ERR,
    output logic [CNT_W-1:0] MATCH_CNT,
    output logic [CNT_W-1:0] ERR_CNT,
    output logic [47:0]      FIRST_EXP,
    output logic [47:0]      FIRST_GOT,
    output logic             BUSY,
    output logic             FAIL
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    chk_state_t  state, state_nxt;
    logic        txn_valid;
    logic        entering;
    logic [47:0] pm_q;
    logic [47:0] gm_p;
    logic        gm_co;
    exp_rec_t    dly_q [LATENCY];
    exp_rec_t    dly_out;
    logic        cmp_en;
    logic        mismatch;
    logic        err_now;

    dsp48a1_golden_model u_gm (
        .opmode (OPMODE),
        .a      (A),
        .b      (B),
        .d      (D),
        .c      (C),
        .pcin   (PCIN),
        .pm     (pm_q),
        .p      (gm_p),
        .co     (gm_co)
    );

    assign txn_valid = IN_VALID && (state == ST_RUN);
    assign dly_out   = dly_q[LATENCY-1];
    assign cmp_en    = dly_out.valid && (state == ST_RUN);

`ifdef DSP_CHK_CARRYOUT_EN
    assign mismatch = (dly_out.p != P) || (dly_out.co != CARRYOUT);
`else
    logic unused_co;
    assign unused_co = CARRYOUT ^ dly_out.co;
    assign mismatch  = (dly_out.p != P);
`endif

    assign err_now = cmp_en && mismatch;
    assign ERR     = err_now;
    assign BUSY    = (state == ST_RUN);
    assign FAIL    = (state == ST_FAIL);

    // Only a fresh start from IDLE clears results; re-arming from FAIL keeps them.
    assign entering = (state == ST_IDLE) && (state_nxt == ST_RUN);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (!STOP && START) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (STOP) begin
                    state_nxt = ST_IDLE;
                end else if ((STOP_ON_ERR != 0) && err_now) begin
                    state_nxt = ST_FAIL;
                end
            end
            ST_FAIL: begin
                if (STOP) begin
                    state_nxt = ST_IDLE;
                end else if (START) begin
                    state_nxt = ST_RUN;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Model P feedback: advances only on transactions accepted in RUN.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pm_q <= 48'd0;
        end else if (entering) begin
            pm_q <= 48'd0;
        end else if (txn_valid) begin
            pm_q <= gm_p;
        end
    end

    // Expected-result delay line; shifts every cycle, bubbles when no transaction.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < LATENCY; i++) begin
                dly_q[i] <= '0;
            end
        end else begin
            dly_q[0] <= '{valid: txn_valid, p: gm_p, co: gm_co};
            for (int i = 1; i < LATENCY; i++) begin
                dly_q[i] <= dly_q[i-1];
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            MATCH_CNT <= '0;
            ERR_CNT   <= '0;
            FIRST_EXP <= 48'd0;
            FIRST_GOT <= 48'd0;
        end else if (entering) begin
            MATCH_CNT <= '0;
            ERR_CNT   <= '0;
            FIRST_EXP <= 48'd0;
            FIRST_GOT <= 48'd0;
        end else if (cmp_en) begin
            if (mismatch) begin
                if (ERR_CNT != CNT_MAX) begin
                    ERR_CNT <= ERR_CNT + CNT_ONE;
                end
                if (ERR_CNT == '0) begin
                    FIRST_EXP <= dly_out.p;
                    FIRST_GOT <= P;
                end
            end else if (MATCH_CNT != CNT_MAX) begin
                MATCH_CNT <= MATCH_CNT + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_dsp48a1_result_checker.sv
// tb/tb_dsp48a1_result_checker.sv - directed self-checking bench for dsp48a1_result_checker
module tb_dsp48a1_result_checker;

`ifdef DSP_CHK_CARRYOUT_EN
    localparam int CO_ERR = 1;
`else
    localparam int CO_ERR = 0;
`endif

    logic        CLK = 1'b0;
    logic        RST, START, STOP, IN_VALID, CARRYOUT;
    logic [7:0]  OPMODE;
    logic [17:0] A, B, D;
    logic [47:0] C, PCIN, P0, P1;

    logic        err0, err1, busy0, busy1, fail0, fail1;
    logic [15:0] mcnt0, ecnt0;
    logic [3:0]  mcnt1, ecnt1;
    logic [47:0] fexp0, fgot0, fexp1, fgot1;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    dsp48a1_result_checker u0 (
        .CLK(CLK), .RST(RST), .START(START), .STOP(STOP), .IN_VALID(IN_VALID),
        .OPMODE(OPMODE), .A(A), .B(B), .D(D), .C(C), .PCIN(PCIN),
        .P(P0), .CARRYOUT(CARRYOUT), .ERR(err0), .MATCH_CNT(mcnt0), .ERR_CNT(ecnt0),
        .FIRST_EXP(fexp0), .FIRST_GOT(fgot0), .BUSY(busy0), .FAIL(fail0)
    );

    dsp48a1_result_checker #(.STOP_ON_ERR(1), .CNT_W(4)) u1 (
        .CLK(CLK), .RST(RST), .START(START), .STOP(STOP), .IN_VALID(IN_VALID),
        .OPMODE(OPMODE), .A(A), .B(B), .D(D), .C(C), .PCIN(PCIN),
        .P(P1), .CARRYOUT(CARRYOUT), .ERR(err1), .MATCH_CNT(mcnt1), .ERR_CNT(ecnt1),
        .FIRST_EXP(fexp1), .FIRST_GOT(fgot1), .BUSY(busy1), .FAIL(fail1)
    );

    typedef struct packed {
        logic [7:0]  op;
        logic [17:0] a;
        logic [17:0] b;
        logic [17:0] d;
        logic [47:0] c;
        logic [47:0] pcin;
        logic [47:0] p;
        logic        co;
    } vec_t;

    vec_t tv [12];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Transaction in cycle 0, DSP result driven in cycle 3 (LATENCY=3).
    task automatic do_txn(input vec_t v, input logic [47:0] p0v, input logic [47:0] p1v,
                          input logic cov, output logic e0, output logic e1, output logic e0_after);
        @(posedge CLK); #1;
        OPMODE = v.op; A = v.a; B = v.b; D = v.d; C = v.c; PCIN = v.pcin; IN_VALID = 1'b1;
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        @(posedge CLK);
        @(posedge CLK); #1;
        P0 = p0v; P1 = p1v; CARRYOUT = cov;
        @(negedge CLK);
        e0 = err0; e1 = err1;
        @(posedge CLK); #1;
        P0 = 48'd0; P1 = 48'd0; CARRYOUT = 1'b0;
        @(negedge CLK);
        e0_after = err0;
    endtask

    task automatic pulse(input logic st, input logic sp);
        @(posedge CLK); #1;
        START = st; STOP = sp;
        @(posedge CLK); #1;
        START = 1'b0; STOP = 1'b0;
    endtask

    logic e0, e1, ea, any_err;

    initial begin
        //          op            a         b         d         c        pcin             p                  co
        tv[0]  = '{8'b00000001, 18'd3,    18'd5,    18'd0,    48'd0,   48'd0,           48'd15,            1'b0};
        tv[1]  = '{8'b00011101, 18'd2,    18'd3,    18'd4,    48'd10,  48'd0,           48'd24,            1'b0};
        tv[2]  = '{8'b10001101, 18'd2,    18'd3,    18'd0,    48'd100, 48'd0,           48'd94,            1'b0};
        tv[3]  = '{8'b00001010, 18'd0,    18'd0,    18'd0,    48'd0,   48'd0,           48'd188,           1'b0};
        tv[4]  = '{8'b01010001, 18'd5,    18'd3,    18'd10,   48'd0,   48'd0,           48'd35,            1'b0};
        tv[5]  = '{8'b00100100, 18'd0,    18'd0,    18'd0,    48'd0,   48'hFFFFFFFFFFFF, 48'd0,            1'b1};
        tv[6]  = '{8'b10000001, 18'd1,    18'd1,    18'd0,    48'd0,   48'd0,           48'hFFFFFFFFFFFF,  1'b1};
        tv[7]  = '{8'b00000011, 18'd1,    18'd2,    18'hABC,  48'd0,   48'd0,           48'hABC000040002,  1'b0};
        tv[8]  = '{8'b00010001, 18'd7,    18'd1,    18'h3FFFF,48'd0,   48'd0,           48'd0,             1'b0};
        tv[9]  = '{8'b00101110, 18'd0,    18'd0,    18'd0,    48'd5,   48'd0,           48'd6,             1'b0};
        tv[10] = '{8'b00000001, 18'h3FFFF,18'h3FFFF,18'd0,    48'd0,   48'd0,           48'h000FFFF80001,  1'b0};
        tv[11] = '{8'b10101101, 18'd2,    18'd3,    18'd0,    48'd100, 48'd0,           48'd93,            1'b0};

        RST = 1'b1; START = 1'b0; STOP = 1'b0; IN_VALID = 1'b0; CARRYOUT = 1'b0;
        OPMODE = 8'd0; A = 18'd0; B = 18'd0; D = 18'd0; C = 48'd0; PCIN = 48'd0;
        P0 = 48'd0; P1 = 48'd0;

        @(negedge CLK);
        chk("rst_err",  64'(err0),  64'd0);
        chk("rst_busy", 64'(busy0), 64'd0);
        chk("rst_fail", 64'(fail0), 64'd0);
        chk("rst_mcnt", 64'(mcnt0), 64'd0);
        chk("rst_ecnt", 64'(ecnt0), 64'd0);
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;

        // Accumulate some state, then reset with two transactions in flight.
        pulse(1'b1, 1'b0);
        chk("start_busy", 64'(busy0), 64'd1);
        do_txn(tv[0], 48'd7, 48'd7, 1'b0, e0, e1, ea);
        chk("pre_rst_err", 64'(e0), 64'd1);
        chk("pre_rst_ecnt", 64'(ecnt0), 64'd1);
        @(posedge CLK); #1;
        OPMODE = tv[0].op; A = tv[0].a; B = tv[0].b; D = 18'd0; IN_VALID = 1'b1;
        @(posedge CLK); #1;
        OPMODE = tv[1].op; A = tv[1].a; B = tv[1].b; D = tv[1].d; C = tv[1].c;
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        RST = 1'b1;
        #2;
        chk("mid_rst_ecnt", 64'(ecnt0), 64'd0);
        chk("mid_rst_fexp", 64'(fexp0), 64'd0);
        chk("mid_rst_fgot", 64'(fgot0), 64'd0);
        chk("mid_rst_busy", 64'(busy0), 64'd0);
        chk("mid_rst_fail1", 64'(fail1), 64'd0);
        chk("mid_rst_ecnt1", 64'(ecnt1), 64'd0);
        #1;
        RST = 1'b0;
        // Re-arm at once with a wrong P: any stale in-flight entry would flag.
        START = 1'b1; P0 = 48'd123; P1 = 48'd123;
        @(posedge CLK); #1;
        START = 1'b0;
        any_err = 1'b0;
        repeat (4) begin
            @(negedge CLK);
            any_err = any_err | err0 | err1;
        end
        P0 = 48'd0; P1 = 48'd0;
        chk("post_rst_no_err", 64'(any_err), 64'd0);
        chk("post_rst_busy", 64'(busy0), 64'd1);
        chk("post_rst_mcnt", 64'(mcnt0), 64'd0);

        // Table of matching transactions, including Pm feedback and carry cases.
        for (int i = 0; i < 12; i++) begin
            do_txn(tv[i], tv[i].p, tv[i].p, tv[i].co, e0, e1, ea);
            chk($sformatf("vec%0d_err0", i), 64'(e0), 64'd0);
            chk($sformatf("vec%0d_err1", i), 64'(e1), 64'd0);
            chk($sformatf("vec%0d_mcnt", i), 64'(mcnt0), 64'(i + 1));
        end

        for (int i = 0; i < 10; i++) begin
            do_txn(tv[0], tv[0].p, tv[0].p, tv[0].co, e0, e1, ea);
        end
        chk("sat_mcnt0", 64'(mcnt0), 64'd22);
        chk("sat_mcnt1", 64'(mcnt1), 64'd15);

        // Error injection on u0.
        do_txn(tv[1], 48'd25, 48'd24, 1'b0, e0, e1, ea);
        chk("inj1_err", 64'(e0), 64'd1);
        chk("inj1_pulse", 64'(ea), 64'd0);
        chk("inj1_err1", 64'(e1), 64'd0);
        chk("inj1_ecnt", 64'(ecnt0), 64'd1);
        chk("inj1_fexp", 64'(fexp0), 64'd24);
        chk("inj1_fgot", 64'(fgot0), 64'd25);
        do_txn(tv[0], 48'd16, 48'd15, 1'b0, e0, e1, ea);
        chk("inj2_err", 64'(e0), 64'd1);
        chk("inj2_ecnt", 64'(ecnt0), 64'd2);
        chk("inj2_fexp", 64'(fexp0), 64'd24);
        chk("inj2_fgot", 64'(fgot0), 64'd25);
        chk("inj2_mcnt", 64'(mcnt0), 64'd22);

        // STOP_ON_ERR instance.
        do_txn(tv[0], 48'd15, 48'd99, 1'b0, e0, e1, ea);
        chk("soe_err1", 64'(e1), 64'd1);
        chk("soe_err0", 64'(e0), 64'd0);
        chk("soe_fail", 64'(fail1), 64'd1);
        chk("soe_busy", 64'(busy1), 64'd0);
        chk("soe_ecnt", 64'(ecnt1), 64'd1);
        chk("soe_fexp", 64'(fexp1), 64'd15);
        chk("soe_fgot", 64'(fgot1), 64'd99);
        do_txn(tv[0], 48'd15, 48'd99, 1'b0, e0, e1, ea);
        chk("soe_ignored_err", 64'(e1), 64'd0);
        chk("soe_ignored_ecnt", 64'(ecnt1), 64'd1);
        pulse(1'b1, 1'b0);
        chk("soe_rearm_busy", 64'(busy1), 64'd1);
        chk("soe_rearm_fail", 64'(fail1), 64'd0);
        chk("soe_rearm_ecnt", 64'(ecnt1), 64'd1);
        chk("soe_rearm_mcnt", 64'(mcnt1), 64'd15);
        chk("run_start_mcnt0", 64'(mcnt0), 64'd24);

        // CARRYOUT-only difference.
        do_txn(tv[5], tv[5].p, tv[5].p, 1'b0, e0, e1, ea);
        chk("co_flip_err", 64'(e0), 64'(CO_ERR));
        chk("co_flip_ecnt", 64'(ecnt0), 64'(2 + CO_ERR));
        do_txn(tv[0], tv[0].p, tv[0].p, tv[0].co, e0, e1, ea);
        chk("co_mcnt", 64'(mcnt0), 64'(24 + (1 - CO_ERR) + 1));

        // After STOP, outputs are ignored.
        pulse(1'b0, 1'b1);
        chk("stop_busy", 64'(busy0), 64'd0);
        do_txn(tv[0], 48'd5, 48'd5, 1'b0, e0, e1, ea);
        chk("stop_no_err", 64'(e0), 64'd0);
        chk("stop_ecnt", 64'(ecnt0), 64'(2 + CO_ERR));

        // START with STOP: stays IDLE, nothing cleared.
        pulse(1'b1, 1'b1);
        chk("startstop_busy", 64'(busy0), 64'd0);
        chk("startstop_ecnt", 64'(ecnt0), 64'(2 + CO_ERR));

        // Fresh start clears results and the Pm feedback (Pm was 15).
        pulse(1'b1, 1'b0);
        chk("restart_busy", 64'(busy0), 64'd1);
        chk("restart_mcnt", 64'(mcnt0), 64'd0);
        chk("restart_ecnt", 64'(ecnt0), 64'd0);
        chk("restart_fexp", 64'(fexp0), 64'd0);
        chk("restart_fgot", 64'(fgot0), 64'd0);
        do_txn('{8'b00001000, 18'd0, 18'd0, 18'd0, 48'd0, 48'd0, 48'd0, 1'b0},
               48'd0, 48'd0, 1'b0, e0, e1, ea);
        chk("pm_clear_err", 64'(e0), 64'd0);
        chk("pm_clear_mcnt", 64'(mcnt0), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
